polynom_inverter: RTL
=====================

// Module: polynom_inverter
// PURPOSE
//   Inverse of the difference-engine evaluator for h(n) = n^3 + 2n^2 + 2n + 1.
//   Given a 20-bit target value, it finds the smallest n with h(n) >= target.
//   It also flags whether h(n) == target, i.e. whether the target lies on the polynomial.
//   It sits beside the evaluator in the polynomial/seven-segment datapath and uses the same start/done_tick handshake.
// PARAMETERS
//   W   20  target width (bits); internal h/f/g registers are W+2 bits wide
//   NW  7   result width; must hold the largest reachable n (101 for W=20)
// PORTS
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous, active-low reset
//   start      in   1   sampled only in IDLE; latches target and begins the search
//   target     in   W   value to invert; sampled on the start cycle only
//   ready      out  1   1 in IDLE, else 0
//   done_tick  out  1   one-cycle pulse in DONE; n_out and exact are valid that cycle
//   n_out      out  NW  smallest n with h(n) >= target; held until the next done
//   exact      out  1   1 iff h(n_out) == target; held with n_out
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE; n, h, f, g, tgt, n_out, exact all 0; done_tick=0.
//   State IDLE:
//     - ready=1.
//     - When start=1: tgt<=target, n<=0, h<=H0(1), f<=F1(5), g<=G2(10); go to SEARCH.
//   State SEARCH, each cycle:
//     - If h >= tgt (unsigned): n_out<=n, exact<=(h==tgt); go to DONE.
//     - Else: n<=n+1, h<=h+f, f<=f+g, g<=g+G_INC(6); stay in SEARCH.
//   State DONE:
//     - done_tick=1 (combinational from state); go to IDLE.
//   Latency: done_tick is high exactly n_out+2 cycles after the clock edge that samples start.
//   Search is bounded: h(101)=1050906 > 2^20-1, so SEARCH lasts at most 102 cycles.
//   Width: internal sums are W+2 bits (22 for W=20), so h/f/g never wrap before exit.
//     - Assertion: h never exceeds 2^(W+2)-1 while in SEARCH.
//   Boundary conditions:
//     - target=0 or 1: exits on the first SEARCH cycle; n_out=0, exact=(target==1).
//     - start while busy (SEARCH or DONE): ignored; tgt unchanged.
//     - start held high: a new search begins in the cycle after DONE (IDLE sees start).
//     - target changing during the search: no effect; only tgt is used.
//     - reset_n low mid-search: immediate return to IDLE with all registers cleared.
//       No done_tick is issued for the aborted request.
//     - n_out/exact: change only on the SEARCH->DONE transition.
//     - Undefined state encodings: go to IDLE.
// STRUCTURE
//   polynom_pkg (shared with the evaluator):
//     - localparams H0=1, F1=5, G2=10, G_INC=6.
//     - State encodings IDLE=2'b00, SEARCH=2'b01, DONE=2'b10.
//   Sub-module polynom_diff_step:
//     - Combinational one-step difference-engine update (h,f,g) -> (h+f, f+g, g+G_INC), W+2 bits.
//     - Reused by the evaluator in a later cleanup.
//   Top level: FSM + registers + compare; single always block for state/data regs with async reset.
// TESTING
//   1. target=1, start pulse -> done_tick 2 cycles after start; n_out=0, exact=1.
//   2. target=6 -> n_out=1, exact=1, done_tick at +3. Then target=52 -> n_out=3, exact=1.
//   3. target=22 -> n_out=3, exact=0 (h(2)=21, h(3)=52).
//      target=0 -> n_out=0, exact=0.
//   4. target=1020201 -> n_out=100, exact=1, done_tick at +102.
//      target=1048575 -> n_out=101, exact=0, done_tick at +103.
//   5. Start a search with target=1048575; pulse start with target=6 on cycle +10
//      -> ignored; result still n_out=101.
//      Then hold start=1, target=6 -> back-to-back results, IDLE for exactly 1 cycle between them.
//   6. target=500000, assert reset_n=0 on cycle +40 -> ready=1, n_out=0, exact=0, no done_tick.
//      After release, target=21 -> n_out=2, exact=1.
//   Scoreboard: reference model computes h(n) by direct formula over n=0..101 and checks every result.

Source files
------------

// File: rtl/polynom_pkg.sv
// Shared constants and state encoding for the h(n) = n^3 + 2n^2 + 2n + 1 evaluator/inverter pair.
package polynom_pkg;

    localparam int unsigned H0    = 1;
    localparam int unsigned F1    = 5;
    localparam int unsigned G2    = 10;
    localparam int unsigned G_INC = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/polynom_inverter_if.sv
// start/done_tick handshake bundle for the polynomial inverter.
interface polynom_inverter_if #(
    parameter int W  = 20,
    parameter int NW = 7
) ();

    logic          start;
    logic [W-1:0]  target;
    logic          ready;
    logic          done_tick;
    logic [NW-1:0] n_out;
    logic          exact;

    modport master (
        output start, target,
        input  ready, done_tick, n_out, exact
    );

    modport slave (
        input  start, target,
        output ready, done_tick, n_out, exact
    );

endinterface

// File: rtl/polynom_diff_step.sv
// One combinational difference-engine step: (h, f, g) -> (h+f, f+g, g+G_INC).
module polynom_diff_step
    import polynom_pkg::*;
#(
    parameter int W = 20
) (
    input  logic [W+1:0] h,
    input  logic [W+1:0] f,
    input  logic [W+1:0] g,
    output logic [W+1:0] h_next,
    output logic [W+1:0] f_next,
    output logic [W+1:0] g_next
);

    typedef logic [W+1:0] word_t;

    assign h_next = h + f;
    assign f_next = f + g;
    assign g_next = g + word_t'(G_INC);

endmodule

// File: rtl/polynom_inverter.sv
// Finds the smallest n with h(n) >= target by stepping a difference engine until it crosses the target.
module polynom_inverter
    import polynom_pkg::*;
#(
    parameter int W  = 20,
    parameter int NW = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    polynom_inverter_if.slave bus
);

    typedef logic [W+1:0] word_t;

    state_t        state, state_next;
    logic [NW-1:0] n, n_next;
    word_t         h, h_next;
    word_t         f, f_next;
    word_t         g, g_next;
    word_t         tgt, tgt_next;
    logic [NW-1:0] n_out_r, n_out_next;
    logic          exact_r, exact_next;

    word_t         h_step, f_step, g_step;

    polynom_diff_step #(.W(W)) u_step (
        .h      (h),
        .f      (f),
        .g      (g),
        .h_next (h_step),
        .f_next (f_step),
        .g_next (g_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            n       <= '0;
            h       <= '0;
            f       <= '0;
            g       <= '0;
            tgt     <= '0;
            n_out_r <= '0;
            exact_r <= 1'b0;
        end else begin
            state   <= state_next;
            n       <= n_next;
            h       <= h_next;
            f       <= f_next;
            g       <= g_next;
            tgt     <= tgt_next;
            n_out_r <= n_out_next;
            exact_r <= exact_next;
        end
    end

    always_comb begin
        state_next = state;
        n_next     = n;
        h_next     = h;
        f_next     = f;
        g_next     = g;
        tgt_next   = tgt;
        n_out_next = n_out_r;
        exact_next = exact_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    tgt_next   = word_t'(bus.target);
                    n_next     = '0;
                    h_next     = word_t'(H0);
                    f_next     = word_t'(F1);
                    g_next     = word_t'(G2);
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (h >= tgt) begin
                    n_out_next = n;
                    exact_next = (h == tgt);
                    state_next = DONE;
                end else begin
                    n_next = n + 1'b1;
                    h_next = h_step;
                    f_next = f_step;
                    g_next = g_step;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done_tick = (state == DONE);
    assign bus.n_out     = n_out_r;
    assign bus.exact     = exact_r;

    // A step that wraps the W+2-bit h register would silently corrupt the search.
    assert property (@(posedge clk) disable iff (!reset_n)
        (state == SEARCH && h < tgt) |-> (h_step >= h));

endmodule
